fifo_rr_sched: RTL and testbench

FIFO_RR_SCHED -- requirements
Module: fifo_rr_sched

---
 rtl/fifo_rr_sched.sv | 170 +++++++++++++++++
 tb/tb_fifo_rr_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin read scheduler in front of four FIFOs.
// Each transaction is IDLE (pick a FIFO) -> ISSUE (pulse its read strobe)
// -> WAIT (capture the returning word), so one word moves every 3 cycles.
// Optional build macro FIFO_SCHED_BURST_EN: keep granting the same FIFO for
// up to BURST_LEN consecutive words before rotating.
module fifo_rr_sched #(
  parameter int DATA_W    = 6,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [3:0]            fifo_empty,
  input  logic [4*DATA_W-1:0]   fifo_data,
  input  logic [3:0]            fifo_valid,
  input  logic                  pause_in,
  input  logic                  cfg_wr,
  input  logic [4:0]            cfg_al_empty,
  input  logic [4:0]            cfg_al_full,
  output logic [3:0]            fifo_rd,
  output logic [4:0]            al_empty_cfg,
  output logic [4:0]            al_full_cfg,
  output logic [DATA_W-1:0]     data_out,
  output logic                  valid_out,
  output logic [1:0]            src_id,
  output logic                  err_sched
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  logic [1:0]        state;
  logic [1:0]        grant;
  logic [1:0]        last_grant;
  logic [CNT_W-1:0]  burst_cnt;
  // Set when reset lands on an issued read, so the word that still comes
  // back in the following cycle is dropped instead of flagged.
  logic              drop_vld;

  logic [1:0]        rr_win;
  logic [1:0]        next_grant;
  logic [CNT_W-1:0]  next_cnt;
  logic [3:0]        grant_oh;
  logic              any_req;
  logic              vld_err;
  logic              cfg_err;
  logic [DATA_W-1:0] lane [4];

  assign any_req  = ~&fifo_empty;
  assign grant_oh = 4'b0001 << grant;
  assign cfg_err  = cfg_wr && !(cfg_al_empty < cfg_al_full);

  // Split the packed FIFO data bus into one word per lane
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i] = fifo_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: first non-empty FIFO starting after last_grant
  always_comb begin
    logic [1:0] cand;
    logic       found;
    cand   = 2'd0;
    found  = 1'b0;
    rr_win = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!found && !fifo_empty[cand]) begin
        rr_win = cand;
        found  = 1'b1;
      end
    end
  end

  // Choose between continuing a burst and rotating to the round-robin winner
  always_comb begin
`ifdef FIFO_SCHED_BURST_EN
    if ((burst_cnt != '0) && (burst_cnt < CNT_W'(BURST_LEN)) && !fifo_empty[last_grant]) begin
      next_grant = last_grant;
      next_cnt   = burst_cnt + CNT_W'(1);
    end else begin
      next_grant = rr_win;
      next_cnt   = CNT_W'(1);
    end
`else
    next_grant = rr_win;
    next_cnt   = burst_cnt;
`endif
  end

  // Returning-valid sanity: only the granted lane, and only while waiting
  always_comb begin
    vld_err = 1'b0;
    case (state)
      IDLE:    vld_err = (|fifo_valid) && !drop_vld;
      ISSUE:   vld_err = |fifo_valid;
      WAIT:    vld_err = !fifo_valid[grant] || (|(fifo_valid & ~grant_oh));
      default: vld_err = 1'b0;
    endcase
  end

  // Transaction FSM: grant selection and the one-cycle read strobe
  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
      burst_cnt  <= '0;
      fifo_rd    <= 4'b0000;
      drop_vld   <= (state == ISSUE);
    end else begin
      fifo_rd  <= 4'b0000;
      drop_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (!pause_in && any_req) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            burst_cnt  <= next_cnt;
            fifo_rd    <= 4'b0001 << next_grant;
            state      <= ISSUE;
          end
        end
        ISSUE:   state <= WAIT;
        WAIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Forward the granted FIFO's word; data_out/src_id hold between pulses
  always_ff @(posedge clk) begin
    if (RESET) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      src_id    <= 2'd0;
    end else begin
      valid_out <= 1'b0;
      if ((state == WAIT) && fifo_valid[grant]) begin
        valid_out <= 1'b1;
        data_out  <= lane[grant];
        src_id    <= grant;
      end
    end
  end

  // Threshold registers, loaded only when the new pair is ordered
  always_ff @(posedge clk) begin
    if (RESET) begin
      al_empty_cfg <= 5'd1;
      al_full_cfg  <= 5'd7;
    end else if (cfg_wr && (cfg_al_empty < cfg_al_full)) begin
      al_empty_cfg <= cfg_al_empty;
      al_full_cfg  <= cfg_al_full;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (RESET) begin
      err_sched <= 1'b0;
    end else if (vld_err || cfg_err) begin
      err_sched <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched: directed bench for fifo_rr_sched with four queue-based
// FIFO models, a transaction-level scheduler model checked every cycle, and
// hand-computed literal expectations for each scenario.
module tb_fifo_rr_sched;

  localparam int DATA_W    = 6;
  localparam int BURST_LEN = 4;

  logic                clk = 1'b0;
  logic                RESET;
  logic [3:0]          fifo_empty;
  logic [4*DATA_W-1:0] fifo_data;
  logic [3:0]          fifo_valid;
  logic                pause_in;
  logic                cfg_wr;
  logic [4:0]          cfg_al_empty;
  logic [4:0]          cfg_al_full;
  logic [3:0]          fifo_rd;
  logic [4:0]          al_empty_cfg;
  logic [4:0]          al_full_cfg;
  logic [DATA_W-1:0]   data_out;
  logic                valid_out;
  logic [1:0]          src_id;
  logic                err_sched;

  always #5 clk = ~clk;

  fifo_rr_sched #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .RESET(RESET), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_valid(fifo_valid), .pause_in(pause_in), .cfg_wr(cfg_wr),
    .cfg_al_empty(cfg_al_empty), .cfg_al_full(cfg_al_full), .fifo_rd(fifo_rd),
    .al_empty_cfg(al_empty_cfg), .al_full_cfg(al_full_cfg), .data_out(data_out),
    .valid_out(valid_out), .src_id(src_id), .err_sched(err_sched)
  );

  int n_chk = 0;
  int n_fail = 0;

  // FIFO environment
  int   fq [4][$];
  logic withhold;

  // Scheduler model: busy counts remaining cycles of the current transaction
  int   m_busy, m_grant, m_last, m_cnt;
  logic m_ignore;
  int   e_rd, e_vout, e_data, e_src, e_err, e_ae, e_af;
  bit   mon_on;

  int rd_log[$];
  int src_log[$];
  int dat_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic model_step();
    int  vld;
    int  g;
    bit  ign;
    bit  found;
    if (RESET) begin
      m_ignore = (e_rd != 0);
      m_busy = 0; m_last = 3; m_cnt = 0; m_grant = 0;
      e_rd = 0; e_vout = 0; e_data = 0; e_src = 0; e_err = 0; e_ae = 1; e_af = 7;
      return;
    end
    vld = int'(fifo_valid);
    ign = m_ignore;
    m_ignore = 1'b0;
    e_vout = 0;
    e_rd = 0;
    if (m_busy == 0) begin
      if (vld != 0 && !ign) e_err = 1;
      if (!pause_in && fifo_empty != 4'hF) begin
        g = 0;
        found = 0;
`ifdef FIFO_SCHED_BURST_EN
        if (m_cnt > 0 && m_cnt < BURST_LEN && !fifo_empty[m_last]) begin
          g = m_last;
          found = 1;
          m_cnt++;
        end
`endif
        if (!found) begin
          for (int k = 1; k <= 4; k++) begin
            if (!found && !fifo_empty[(m_last + k) % 4]) begin
              g = (m_last + k) % 4;
              found = 1;
            end
          end
          m_cnt = 1;
        end
        m_grant = g;
        m_last = g;
        e_rd = 1 << g;
        m_busy = 2;
      end
    end else if (m_busy == 2) begin
      if (vld != 0) e_err = 1;
      m_busy = 1;
    end else begin
      if (vld[m_grant]) begin
        e_vout = 1;
        e_data = int'((fifo_data >> (m_grant * DATA_W)) & ((1 << DATA_W) - 1));
        e_src = m_grant;
      end else begin
        e_err = 1;
      end
      if ((vld & ~(1 << m_grant)) != 0) e_err = 1;
      m_busy = 0;
    end
    if (cfg_wr) begin
      if (cfg_al_empty < cfg_al_full) begin
        e_ae = int'(cfg_al_empty);
        e_af = int'(cfg_al_full);
      end else begin
        e_err = 1;
      end
    end
  endtask

  task automatic env_update(input logic [3:0] rd);
    int w;
    for (int i = 0; i < 4; i++) begin
      fifo_valid[i] = 1'b0;
      if (rd[i]) begin
        w = 0;
        if (fq[i].size() > 0) w = fq[i].pop_front();
        if (withhold) begin
          withhold = 1'b0;
        end else begin
          fifo_valid[i] = 1'b1;
          fifo_data[i*DATA_W +: DATA_W] = w[DATA_W-1:0];
        end
      end
      fifo_empty[i] = (fq[i].size() == 0);
    end
  endtask

  // One clock: compare at negedge, advance model, then update FIFOs after the edge
  task automatic cyc();
    logic [3:0] rd_seen;
    @(negedge clk);
    if (mon_on) begin
      chk("fifo_rd", fifo_rd, e_rd);
      chk("valid_out", valid_out, e_vout);
      chk("data_out", data_out, e_data);
      chk("src_id", src_id, e_src);
      chk("err_sched", err_sched, e_err);
      chk("al_empty_cfg", al_empty_cfg, e_ae);
      chk("al_full_cfg", al_full_cfg, e_af);
      if (fifo_rd != 4'b0) rd_log.push_back(int'(fifo_rd));
      if (valid_out) begin
        src_log.push_back(int'(src_id));
        dat_log.push_back(int'(data_out));
      end
    end
    rd_seen = fifo_rd;
    model_step();
    @(posedge clk);
    #1;
    env_update(rd_seen);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push(input int lane_i, input int v);
    fq[lane_i].push_back(v);
    fifo_empty[lane_i] = 1'b0;
  endtask

  task automatic wait_rd(input string nm);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (fifo_rd != 4'b0) break;
    end
    chk(nm, fifo_rd != 4'b0, 1);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    src_log.delete();
    dat_log.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
  endtask

  initial begin
    int n_exp;
    RESET = 1'b1; fifo_empty = 4'hF; fifo_data = '0; fifo_valid = 4'b0;
    pause_in = 1'b0; cfg_wr = 1'b0; cfg_al_empty = 5'd0; cfg_al_full = 5'd0;
    withhold = 1'b0; mon_on = 1'b0;
    e_rd = 0; m_ignore = 1'b0;
    cyc();
    cyc();
    mon_on = 1'b1;
    RESET = 1'b0;

    // Reset values
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_src_id", src_id, 0);
    chk("rst_err", err_sched, 0);
    chk("rst_al_empty", al_empty_cfg, 1);
    chk("rst_al_full", al_full_cfg, 7);

    // FIFO0 and FIFO2 non-empty: reads 0001 then 0100
    clear_logs();
    push(0, 21);
    push(2, 42);
    run(10);
    chk("t1_rd_cnt", rd_log.size(), 2);
    chk("t1_rd0", qget(rd_log, 0), 1);
    chk("t1_rd1", qget(rd_log, 1), 4);
    chk("t1_src0", qget(src_log, 0), 0);
    chk("t1_src1", qget(src_log, 1), 2);
    chk("t1_dat0", qget(dat_log, 0), 21);
    chk("t1_dat1", qget(dat_log, 1), 42);

    // Pause raised during ISSUE: word still forwarded, no new read
    clear_logs();
    push(1, 7);
    push(1, 8);
    wait_rd("t2_wait_rd");
    chk("t2_first_rd", fifo_rd, 2);
    pause_in = 1'b1;
    run(8);
    chk("t2_rd_paused", rd_log.size(), 1);
    chk("t2_fwd_cnt", src_log.size(), 1);
    chk("t2_fwd_dat", qget(dat_log, 0), 7);
    pause_in = 1'b0;
    run(6);
    chk("t2_rd_resume", qget(rd_log, 1), 2);
    chk("t2_dat_resume", qget(dat_log, 1), 8);
    chk("t2_err", err_sched, 0);

    // Threshold writes: valid pair loads, inverted pair rejected
    cfg_al_empty = 5'd3; cfg_al_full = 5'd10; cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0;
    chk("t3_ae", al_empty_cfg, 3);
    chk("t3_af", al_full_cfg, 10);
    chk("t3_err0", err_sched, 0);
    cfg_al_empty = 5'd9; cfg_al_full = 5'd4; cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0;
    chk("t3_ae_kept", al_empty_cfg, 3);
    chk("t3_af_kept", al_full_cfg, 10);
    chk("t3_err1", err_sched, 1);
    do_reset();
    chk("t3_err_cleared", err_sched, 0);
    chk("t3_ae_rst", al_empty_cfg, 1);

    // Withheld valid: sticky error through later traffic until reset
    clear_logs();
    withhold = 1'b1;
    push(3, 5);
    run(6);
    chk("t4_err", err_sched, 1);
    chk("t4_no_fwd", src_log.size(), 0);
    push(0, 9);
    run(8);
    chk("t4_err_sticky", err_sched, 1);
    chk("t4_later_dat", qget(dat_log, 0), 9);
    chk("t4_later_src", qget(src_log, 0), 0);
    do_reset();
    chk("t4_err_rst", err_sched, 0);

    // Reset during WAIT
    clear_logs();
    push(1, 11);
    wait_rd("t5_wait_rd");
    cyc();
    do_reset();
    chk("t5_rd", fifo_rd, 0);
    chk("t5_vout", valid_out, 0);
    chk("t5_data", data_out, 0);
    chk("t5_src", src_id, 0);
    chk("t5_err", err_sched, 0);
    chk("t5_af", al_full_cfg, 7);
    run(4);
    chk("t5_err_after", err_sched, 0);
    chk("t5_no_fwd", src_log.size(), 0);

    // Reset during ISSUE: returning word arrives in IDLE and is dropped
    push(2, 12);
    wait_rd("t5b_wait_rd");
    do_reset();
    run(4);
    chk("t5b_err", err_sched, 0);
    chk("t5b_no_fwd", src_log.size(), 0);

    // All FIFOs loaded with 6 words
    clear_logs();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 6; k++) push(i, 10 * i + k + 1);
`ifdef FIFO_SCHED_BURST_EN
    n_exp = 8;
`else
    n_exp = 5;
`endif
    for (int i = 0; i < 80; i++) begin
      if (rd_log.size() >= n_exp) break;
      cyc();
    end
    chk("t6_rd_cnt_reached", rd_log.size() >= n_exp, 1);
    chk("t6_dat0", qget(dat_log, 0), 1);
`ifdef FIFO_SCHED_BURST_EN
    for (int i = 0; i < 8; i++) chk("t6_burst_rd", qget(rd_log, i), (i < 4) ? 1 : 2);
    chk("t6_dat1", qget(dat_log, 1), 2);
`else
    chk("t6_rd0", qget(rd_log, 0), 1);
    chk("t6_rd1", qget(rd_log, 1), 2);
    chk("t6_rd2", qget(rd_log, 2), 4);
    chk("t6_rd3", qget(rd_log, 3), 8);
    chk("t6_rd4", qget(rd_log, 4), 1);
    chk("t6_dat1", qget(dat_log, 1), 11);
`endif
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
